// File: rtl/pc_branch_ctrl_if.sv
// Branch/PC control bus between the decode/comparator side and pc_branch_ctrl.
// master: drives instruction/comparator inputs and consumes the PC, branch and trap outputs.
// slave : the pc_branch_ctrl block itself.
interface pc_branch_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             i_stall;
    logic             i_is_branch;
    logic             i_is_jal;
    logic             i_is_jalr;
    logic [2:0]       i_br_type;
    logic             i_br_less;
    logic             i_br_equal;
    logic [31:0]      i_alu_target;
    logic             i_trap_ack;
    logic             o_br_un;
    logic [31:0]      o_pc;
    logic [31:0]      o_pc_four;
    logic             o_taken;
    logic             o_trap;
    logic [31:0]      o_trap_addr;
    logic [CNT_W-1:0] o_br_cnt;
    logic [CNT_W-1:0] o_taken_cnt;

    modport master (
        output i_stall, i_is_branch, i_is_jal, i_is_jalr, i_br_type,
               i_br_less, i_br_equal, i_alu_target, i_trap_ack,
        input  o_br_un, o_pc, o_pc_four, o_taken, o_trap, o_trap_addr,
               o_br_cnt, o_taken_cnt
    );

    modport slave (
        input  i_stall, i_is_branch, i_is_jal, i_is_jalr, i_br_type,
               i_br_less, i_br_equal, i_alu_target, i_trap_ack,
        output o_br_un, o_pc, o_pc_four, o_taken, o_trap, o_trap_addr,
               o_br_cnt, o_taken_cnt
    );
endinterface

// File: rtl/pc_branch_ctrl.sv
// PC register and branch resolution stage.
// Decodes funct3 into the comparator unsigned-select, resolves taken/not-taken,
// selects the next PC (PC+4 / branch / JAL / JALR), traps on a misaligned
// redirect target and keeps saturating branch statistics.
// Ports: i_clk, i_rst_n (async active-low), bus (pc_branch_ctrl_if.slave).
// o_br_un, o_taken and o_pc_four are combinational; all other outputs are registered.
module pc_branch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
    parameter int unsigned CNT_W    = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    pc_branch_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t           state_q;
    logic [31:0]      pc_q;
    logic             trap_q;
    logic [31:0]      trap_addr_q;
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] taken_cnt_q;

    logic        cond_c;
    logic [31:0] tgt_c;
    logic        taken_c;
    logic        mis_c;
    logic        count_c;
    logic [31:0] pc_four_c;

    // Branch condition from funct3 and comparator flags
    always_comb begin
        cond_c = 1'b0;
        unique case (bus.i_br_type)
            3'b000:         cond_c =  bus.i_br_equal;
            3'b001:         cond_c = !bus.i_br_equal;
            3'b100, 3'b110: cond_c =  bus.i_br_less;
            3'b101, 3'b111: cond_c = !bus.i_br_less;
            default:        cond_c = 1'b0;
        endcase
    end

    // Redirect target; JALR clears bit 0, bit 1 is what flags misalignment
    assign tgt_c     = bus.i_is_jalr ? (bus.i_alu_target & 32'hFFFF_FFFE) : bus.i_alu_target;
    assign taken_c   = (state_q == ST_RUN) &
                       (bus.i_is_jalr | bus.i_is_jal | (bus.i_is_branch & cond_c));
    assign mis_c     = taken_c & tgt_c[1];
    assign pc_four_c = pc_q + 32'd4;
    assign count_c   = (state_q == ST_RUN) & !bus.i_stall & !mis_c &
                       bus.i_is_branch & !bus.i_is_jal & !bus.i_is_jalr;

    // PC / trap FSM and saturating statistics
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            trap_q      <= 1'b0;
            trap_addr_q <= 32'h0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (!bus.i_stall) begin
                        if (mis_c) begin
                            trap_addr_q <= tgt_c;
                            trap_q      <= 1'b1;
                            state_q     <= ST_TRAP;
                        end else begin
                            pc_q <= taken_c ? tgt_c : pc_four_c;
                        end
                    end
                end
                ST_TRAP: begin
                    if (bus.i_trap_ack) begin
                        pc_q    <= TRAP_VEC;
                        trap_q  <= 1'b0;
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase

            if (count_c) begin
                if (br_cnt_q != CNT_MAX) begin
                    br_cnt_q <= br_cnt_q + CNT_W'(1);
                end
                if (cond_c && (taken_cnt_q != CNT_MAX)) begin
                    taken_cnt_q <= taken_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.o_br_un     = bus.i_br_type[1];
    assign bus.o_pc        = pc_q;
    assign bus.o_pc_four   = pc_four_c;
    assign bus.o_taken     = taken_c;
    assign bus.o_trap      = trap_q;
    assign bus.o_trap_addr = trap_addr_q;
    assign bus.o_br_cnt    = br_cnt_q;
    assign bus.o_taken_cnt = taken_cnt_q;
endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Self-checking bench for pc_branch_ctrl: vector table with a registered-result
// scoreboard queue, plus hand sequences for wrap, saturation and async reset.
module tb_pc_branch_ctrl;
    logic clk;
    logic rst_n;

    pc_branch_ctrl_if #(.CNT_W(16)) bus ();

    pc_branch_ctrl #(
        .RESET_PC(32'h0000_0000),
        .TRAP_VEC(32'h0000_0100),
        .CNT_W   (16)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall, br, jal, jalr;
        logic [2:0]  typ;
        logic        less, eq;
        logic [31:0] tgt;
        logic        ack;
        logic        e_un, e_tk;
        logic [31:0] e_four;
        logic [31:0] e_pc;
        logic        e_trap;
        logic [31:0] e_taddr;
        logic [15:0] e_bc, e_tc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        trap;
        logic [31:0] taddr;
        logic [15:0] bc, tc;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[20];
    exp_t sb_q[$];

    function automatic vec_t mk(
        input logic st, input logic br, input logic jal, input logic jalr,
        input logic [2:0] typ, input logic less, input logic eq,
        input logic [31:0] tgt, input logic ack,
        input logic un, input logic tk, input logic [31:0] four,
        input logic [31:0] pc, input logic trap, input logic [31:0] taddr,
        input logic [15:0] bc, input logic [15:0] tc);
        vec_t v;
        v.stall = st; v.br = br; v.jal = jal; v.jalr = jalr; v.typ = typ;
        v.less = less; v.eq = eq; v.tgt = tgt; v.ack = ack;
        v.e_un = un; v.e_tk = tk; v.e_four = four; v.e_pc = pc;
        v.e_trap = trap; v.e_taddr = taddr; v.e_bc = bc; v.e_tc = tc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic br, input logic jal, input logic jalr,
                         input logic [2:0] typ, input logic less, input logic eq,
                         input logic [31:0] tgt, input logic ack);
        bus.i_stall      = st;
        bus.i_is_branch  = br;
        bus.i_is_jal     = jal;
        bus.i_is_jalr    = jalr;
        bus.i_br_type    = typ;
        bus.i_br_less    = less;
        bus.i_br_equal   = eq;
        bus.i_alu_target = tgt;
        bus.i_trap_ack   = ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag, input exp_t e);
        chk({tag, " pc"},        bus.o_pc, e.pc);
        chk({tag, " trap"},      32'(bus.o_trap), 32'(e.trap));
        chk({tag, " trap_addr"}, bus.o_trap_addr, e.taddr);
        chk({tag, " br_cnt"},    32'(bus.o_br_cnt), 32'(e.bc));
        chk({tag, " taken_cnt"}, 32'(bus.o_taken_cnt), 32'(e.tc));
    endtask

    initial begin
        exp_t e;
        vec_t v;

        //            st br jal jalr typ   ls eq tgt            ack un tk four           pc             trap taddr          bc  tc
        vecs[0]  = mk(0, 0, 0, 0, 3'b000, 0, 0, 32'h0,         0, 0, 0, 32'h4,         32'h4,         0, 32'h0,         0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 3'b000, 0, 0, 32'h0,         0, 0, 0, 32'h8,         32'h8,         0, 32'h0,         0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 3'b000, 0, 0, 32'h0,         0, 0, 0, 32'hC,         32'hC,         0, 32'h0,         0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 3'b110, 1, 0, 32'h40,        0, 1, 1, 32'h10,        32'h40,        0, 32'h0,         1, 1);
        vecs[4]  = mk(0, 1, 0, 0, 3'b101, 1, 0, 32'h80,        0, 0, 0, 32'h44,        32'h44,        0, 32'h0,         2, 1);
        vecs[5]  = mk(0, 0, 0, 1, 3'b000, 0, 0, 32'h1001,      0, 0, 1, 32'h48,        32'h1000,      0, 32'h0,         2, 1);
        vecs[6]  = mk(0, 0, 0, 1, 3'b000, 0, 0, 32'h1006,      0, 0, 1, 32'h1004,      32'h1000,      1, 32'h1006,      2, 1);
        vecs[7]  = mk(0, 1, 0, 0, 3'b000, 0, 1, 32'h200,       0, 0, 0, 32'h1004,      32'h1000,      1, 32'h1006,      2, 1);
        vecs[8]  = mk(1, 0, 1, 0, 3'b011, 0, 0, 32'h204,       0, 1, 0, 32'h1004,      32'h1000,      1, 32'h1006,      2, 1);
        vecs[9]  = mk(0, 1, 0, 1, 3'b110, 1, 0, 32'h300,       0, 1, 0, 32'h1004,      32'h1000,      1, 32'h1006,      2, 1);
        vecs[10] = mk(0, 0, 0, 0, 3'b000, 0, 0, 32'h0,         1, 0, 0, 32'h1004,      32'h100,       0, 32'h1006,      2, 1);
        vecs[11] = mk(1, 1, 0, 0, 3'b000, 0, 1, 32'h300,       0, 0, 1, 32'h104,       32'h100,       0, 32'h1006,      2, 1);
        vecs[12] = mk(0, 1, 0, 0, 3'b000, 0, 1, 32'h300,       0, 0, 1, 32'h104,       32'h300,       0, 32'h1006,      3, 2);
        vecs[13] = mk(0, 0, 0, 0, 3'b000, 0, 0, 32'h0,         1, 0, 0, 32'h304,       32'h304,       0, 32'h1006,      3, 2);
        vecs[14] = mk(0, 1, 0, 0, 3'b001, 0, 1, 32'h500,       0, 0, 0, 32'h308,       32'h308,       0, 32'h1006,      4, 2);
        vecs[15] = mk(0, 1, 0, 0, 3'b010, 1, 1, 32'h500,       0, 1, 0, 32'h30C,       32'h30C,       0, 32'h1006,      5, 2);
        vecs[16] = mk(0, 1, 1, 0, 3'b000, 0, 1, 32'h2000,      0, 0, 1, 32'h310,       32'h2000,      0, 32'h1006,      5, 2);
        vecs[17] = mk(0, 1, 0, 0, 3'b100, 1, 0, 32'h2002,      0, 0, 1, 32'h2004,      32'h2000,      1, 32'h2002,      5, 2);
        vecs[18] = mk(0, 0, 0, 0, 3'b000, 0, 0, 32'h0,         1, 0, 0, 32'h2004,      32'h100,       0, 32'h2002,      5, 2);
        vecs[19] = mk(0, 1, 0, 0, 3'b111, 0, 0, 32'h180,       0, 1, 1, 32'h104,       32'h180,       0, 32'h2002,      6, 3);

        // Reset state
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 3'b000, 0, 0, 32'h0, 0);
        tick();
        tick();
        e.pc = 32'h0; e.trap = 1'b0; e.taddr = 32'h0; e.bc = 16'h0; e.tc = 16'h0;
        chk_regs("reset", e);
        chk("reset pc_four", bus.o_pc_four, 32'h4);
        rst_n = 1'b1;

        // Vector table: combinational checks now, registered results via scoreboard
        for (int i = 0; i < 20; i++) begin
            v = vecs[i];
            drive(v.stall, v.br, v.jal, v.jalr, v.typ, v.less, v.eq, v.tgt, v.ack);
            #1;
            chk($sformatf("v%0d br_un", i), 32'(bus.o_br_un), 32'(v.e_un));
            chk($sformatf("v%0d taken", i), 32'(bus.o_taken), 32'(v.e_tk));
            chk($sformatf("v%0d pc_four", i), bus.o_pc_four, v.e_four);
            e.pc = v.e_pc; e.trap = v.e_trap; e.taddr = v.e_taddr; e.bc = v.e_bc; e.tc = v.e_tc;
            sb_q.push_back(e);
            tick();
            if (sb_q.size() == 0) begin
                chk($sformatf("v%0d scoreboard empty", i), 32'h1, 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk_regs($sformatf("v%0d", i), e);
            end
        end

        // PC wrap at the top of the address space
        drive(0, 0, 1, 0, 3'b000, 0, 0, 32'hFFFF_FFFC, 0);
        tick();
        chk("wrap pc top", bus.o_pc, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 3'b000, 0, 0, 32'h0, 0);
        #1;
        chk("wrap pc_four", bus.o_pc_four, 32'h0);
        tick();
        chk("wrap pc", bus.o_pc, 32'h0);

        // Counter saturation: enough taken BEQs to reach all-ones and beyond
        drive(0, 1, 0, 0, 3'b000, 0, 1, 32'h0, 0);
        for (int i = 0; i < 65536; i++) begin
            tick();
        end
        chk("sat br_cnt", 32'(bus.o_br_cnt), 32'h0000_FFFF);
        chk("sat taken_cnt", 32'(bus.o_taken_cnt), 32'h0000_FFFF);
        chk("sat pc", bus.o_pc, 32'h0);
        drive(0, 1, 0, 0, 3'b001, 0, 1, 32'h40, 0);
        tick();
        chk("sat hold br_cnt", 32'(bus.o_br_cnt), 32'h0000_FFFF);
        chk("sat hold taken_cnt", 32'(bus.o_taken_cnt), 32'h0000_FFFF);
        chk("sat hold pc", bus.o_pc, 32'h4);

        // Async reset in the middle of a trap
        drive(0, 0, 0, 1, 3'b000, 0, 0, 32'h6, 0);
        tick();
        chk("pre-reset trap", 32'(bus.o_trap), 32'h1);
        chk("pre-reset trap_addr", bus.o_trap_addr, 32'h6);
        drive(0, 0, 0, 0, 3'b000, 0, 0, 32'h0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        e.pc = 32'h0; e.trap = 1'b0; e.taddr = 32'h0; e.bc = 16'h0; e.tc = 16'h0;
        chk_regs("async reset", e);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post-reset run pc", bus.o_pc, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
